// File: rtl/ps2_keypad_pkg.sv
// Shared constants for the PS/2 keypad: prefix bytes, the set-2 scancodes of
// the 16 hex keys and the receiver state encoding.
package ps2_keypad_pkg;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    // Scancode for hex key n, laid out like the 4x4 Chip-8 pad 1-2-3-C / 4-5-6-D / ...
    localparam logic [7:0] SC_KEY_0 = 8'h22;
    localparam logic [7:0] SC_KEY_1 = 8'h16;
    localparam logic [7:0] SC_KEY_2 = 8'h1E;
    localparam logic [7:0] SC_KEY_3 = 8'h26;
    localparam logic [7:0] SC_KEY_4 = 8'h15;
    localparam logic [7:0] SC_KEY_5 = 8'h1D;
    localparam logic [7:0] SC_KEY_6 = 8'h24;
    localparam logic [7:0] SC_KEY_7 = 8'h1C;
    localparam logic [7:0] SC_KEY_8 = 8'h1B;
    localparam logic [7:0] SC_KEY_9 = 8'h23;
    localparam logic [7:0] SC_KEY_A = 8'h1A;
    localparam logic [7:0] SC_KEY_B = 8'h21;
    localparam logic [7:0] SC_KEY_C = 8'h25;
    localparam logic [7:0] SC_KEY_D = 8'h2D;
    localparam logic [7:0] SC_KEY_E = 8'h2B;
    localparam logic [7:0] SC_KEY_F = 8'h2A;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ps2_keypad_if.sv
// Keypad state bundle handed from the PS/2 decoder to the Chip-8 core.
interface ps2_keypad_if;
    logic [15:0] keys;
    logic        key_event;
    logic [3:0]  key_code;
    logic        key_down;
    logic        frame_error;

    modport master (output keys, key_event, key_code, key_down, frame_error);
    modport slave  (input  keys, key_event, key_code, key_down, frame_error);
endinterface

// File: rtl/ps2_keypad_rx.sv
// PS/2 byte receiver: input synchronisers, falling-edge detect, 11-bit frame
// checker and an inactivity timeout that abandons partial frames.
module ps2_keypad_rx
    import ps2_keypad_pkg::*;
#(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_error
);
    localparam int TW = $clog2(TIMEOUT);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_prev_q;
    logic          fall_q;
    logic          bit_q;
    rx_state_e     state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    rx_byte_q;
    logic          rx_valid_q;
    logic          rx_error_q;

    // bit_q is registered alongside fall_q so the FSM sees the data bit that
    // was present when the clock edge was observed.
    always_ff @(posedge clk) begin
        if (res) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
            bit_q       <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_sync_q[1];
            fall_q      <= clk_prev_q & ~clk_sync_q[1];
            bit_q       <= data_sync_q[1];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= RX_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
            if (fall_q) begin
                tmo_q <= '0;
                case (state_q)
                    RX_IDLE: begin
                        if (!bit_q) begin
                            state_q   <= RX_DATA;
                            bit_cnt_q <= 3'd0;
                        end else begin
                            rx_error_q <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shift_q   <= {bit_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        parity_q <= bit_q;
                        state_q  <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (bit_q && ((^shift_q) ^ parity_q)) begin
                            rx_byte_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            rx_error_q <= 1'b1;
                        end
                        state_q <= RX_IDLE;
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end else if (state_q != RX_IDLE) begin
                // A gap of TIMEOUT-1 quiet cycles survives; the TIMEOUT-th aborts.
                if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_q    <= RX_IDLE;
                    tmo_q      <= '0;
                    rx_error_q <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end
        end
    end

    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign rx_error = rx_error_q;

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard to Chip-8 hex keypad: prefix tracking (E0/F0), scancode
// lookup and the held-key vector with change events.
module ps2_keypad
    import ps2_keypad_pkg::*;
#(
    parameter int TIMEOUT = 50000
) (
    input  logic         clk,
    input  logic         res,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_keypad_if.master kp
);
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_error;

    logic        map_hit;
    logic [3:0]  map_code;

    logic [15:0] keys_q, keys_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic        event_q, event_d;
    logic [3:0]  code_q, code_d;
    logic        down_q, down_d;

    ps2_keypad_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .clk      (clk),
        .res      (res),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_error (rx_error)
    );

    always_comb begin
        map_hit  = 1'b1;
        map_code = 4'h0;
        case (rx_byte)
            SC_KEY_0: map_code = 4'h0;
            SC_KEY_1: map_code = 4'h1;
            SC_KEY_2: map_code = 4'h2;
            SC_KEY_3: map_code = 4'h3;
            SC_KEY_4: map_code = 4'h4;
            SC_KEY_5: map_code = 4'h5;
            SC_KEY_6: map_code = 4'h6;
            SC_KEY_7: map_code = 4'h7;
            SC_KEY_8: map_code = 4'h8;
            SC_KEY_9: map_code = 4'h9;
            SC_KEY_A: map_code = 4'hA;
            SC_KEY_B: map_code = 4'hB;
            SC_KEY_C: map_code = 4'hC;
            SC_KEY_D: map_code = 4'hD;
            SC_KEY_E: map_code = 4'hE;
            SC_KEY_F: map_code = 4'hF;
            default:  map_hit  = 1'b0;
        endcase
    end

    // Only a real change of a held bit raises an event, so typematic repeats
    // of an already-held key are silent.
    always_comb begin
        keys_d  = keys_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        event_d = 1'b0;
        code_d  = code_q;
        down_d  = down_q;
        if (rx_valid) begin
            if (rx_byte == SC_E0) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_F0) begin
                brk_d = 1'b1;
            end else begin
                if (!ext_q && map_hit && (keys_q[map_code] == brk_q)) begin
                    keys_d[map_code] = ~brk_q;
                    event_d          = 1'b1;
                    code_d           = map_code;
                    down_d           = ~brk_q;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            keys_q  <= 16'h0000;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            event_q <= 1'b0;
            code_q  <= 4'h0;
            down_q  <= 1'b0;
        end else begin
            keys_q  <= keys_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            event_q <= event_d;
            code_q  <= code_d;
            down_q  <= down_d;
        end
    end

    assign kp.keys        = keys_q;
    assign kp.key_event   = event_q;
    assign kp.key_code    = code_q;
    assign kp.key_down    = down_q;
    assign kp.frame_error = rx_error;

endmodule

// File: doc/ps2_keypad.md
# ps2_keypad

Converts the PS/2 keyboard stream from the user_io block into the 16-key Chip-8 hex keypad state consumed by the chip8 machine. It sits between user_io's ps2_clk/ps2_data outputs and chip8's keyboard input. It receives and checks 11-bit PS/2 frames, tracks the make, break (F0) and extended (E0) prefixes, and keeps a 16-bit held-key vector.

## Interface
- TIMEOUT, 50000: clk cycles with no ps2_clk falling edge before a partial frame is abandoned (2 ms at 25 MHz).
- clk  in  1  system clock (clk_25M); must be at least 16x the ps2_clk rate.
- res  in  1  reset, synchronous, active-high.
- ps2_clk  in  1  PS/2 clock from user_io, asynchronous to clk.
- ps2_data  in  1  PS/2 data from user_io, asynchronous to clk.
- keys  out  16  held-key vector; bit n is set while hex key n is down.
- key_event  out  1  one-cycle pulse when a bit of keys changes.
- key_code  out  4  hex key of the last event; valid with key_event.
- key_down  out  1  1 = press, 0 = release; valid with key_event.
- frame_error  out  1  one-cycle pulse on a bad start, parity, stop or timeout.

## Operation
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - A falling edge is detected from the synchronised ps2_clk (previous = 1, current = 0).
- Receiver FSM states: IDLE, DATA, PARITY, STOP. Every bit is sampled on a detected falling edge.
  - IDLE: sampled data 0 (start bit) -> DATA with bit count 0. Sampled data 1 -> frame_error pulse, stay in IDLE.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: accept the byte only if data = 1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity). Otherwise pulse frame_error. Either way -> IDLE.
  - Timeout: the counter reloads on every falling edge. In any state other than IDLE, reaching TIMEOUT -> IDLE plus a frame_error pulse. The counter does not count in IDLE.
- Decoder, on each accepted byte:
  - E0 sets ext.
  - F0 sets brk.
  - Any other byte: if ext = 0 and the byte is in the keymap, set keys[n] (brk = 0) or clear it (brk = 1). key_event is pulsed only if the bit actually changes. Then clear ext and brk.
  - Unmapped bytes and extended codes are ignored, but still clear ext and brk.
- Keymap (set-2 scancode -> hex key):
  - 16->1, 1E->2, 26->3, 25->C
  - 15->4, 1D->5, 24->6, 2D->D
  - 1C->7, 1B->8, 23->9, 2B->E
  - 1A->A, 22->0, 21->B, 2A->F
- Several keys may be held at once. Typematic repeat makes no change to keys and raises no event.
- A frame_error does not change ext, brk or keys.

## Timing
- Reset values:
  - keys = 0, key_event = 0, key_code = 0, key_down = 0, frame_error = 0.
  - FSM = IDLE, ext = 0, brk = 0, timeout counter = 0.
  - Synchroniser flops = 1.
- Reset mid-frame discards the partial frame and clears prefixes and keys. No event or error pulse is produced.
- Latency:
  - ps2_clk pin fall -> edge detect: 3 clk.
  - Stop-bit edge -> byte accepted: +1 clk.
  - keys, key_event, key_code, key_down update: +1 clk.
  - Total, stop-bit pin edge -> keys: 5 clk.
- frame_error asserts 1 clk after the offending edge or after the timeout expiry.
- key_event and frame_error are never high for more than one cycle and never occur in the same cycle.
- Timeout count: a frame left idle for exactly TIMEOUT-1 cycles survives. At TIMEOUT cycles it aborts.

## Structure
- Shared include ps2_keys.vh, in the style of blitter.vh: prefix constants (E0, F0), the 16 scancode constants, FSM state encodings.
- Sub-module ps2_rx: synchronisers, edge detect, frame FSM and timeout. Outputs rx_byte[7:0], rx_valid and rx_error.
- ps2_keypad itself: prefix tracking, keymap lookup (case statement) and the keys register.

## Test plan
- Send frame 16, then frame 1E -> keys = 0x0006; two key_event pulses, key_code 1 then 2, key_down = 1 for both.
- From keys = 0x0006, send F0 16 -> keys = 0x0004; key_event with key_code = 1, key_down = 0. Send 16 twice more -> exactly one event.
- Send frame 1C with a wrong parity bit -> one frame_error pulse, keys unchanged, no key_event.
- Send start + 4 data bits, stall TIMEOUT cycles -> frame_error, FSM back to IDLE. Next full frame 2A -> keys[15] set.
- Send E0 1C (extended code) -> no change. Then a plain 1C -> keys[7] set, proving ext is cleared.
- With keys = 0xFFFF, assert res mid-frame for one cycle -> keys = 0, no pulses. Next clean frame 22 -> keys = 0x0001.
